// File: rtl/quad_solver_arbiter_pkg.sv
// Shared limits and tag type for quad_solver_arbiter.
package quad_arb_pkg;

  localparam int DATA_WIDTH_DEF = 24;
  localparam int MAX_REQ        = 8;
  localparam int IDX_W          = $clog2(MAX_REQ);

  typedef struct packed {
    logic             valid;
    logic [IDX_W-1:0] idx;
  } tag_t;

endpackage

// File: rtl/quad_solver_arbiter_rr.sv
// Combinational round-robin grant over an eligible vector; the pointer lives in the parent.
module rr_arbiter #(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         eligible_i,
  input  logic [$clog2(NUM_REQ)-1:0] rr_ptr_i,
  output logic [NUM_REQ-1:0]         grant_o,
  output logic [$clog2(NUM_REQ)-1:0] grant_idx_o,
  output logic                       any_grant_o
);

  localparam int TAG_W = $clog2(NUM_REQ);

  always_comb begin
    int unsigned        idx;
    logic [NUM_REQ-1:0] sh;
    grant_o     = '0;
    grant_idx_o = '0;
    any_grant_o = 1'b0;
    idx         = 0;
    sh          = '0;
    for (int unsigned off = 0; off < NUM_REQ; off++) begin
      idx = 32'(rr_ptr_i) + off;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      sh = eligible_i >> idx;
      if (!any_grant_o && sh[0]) begin
        any_grant_o = 1'b1;
        grant_o     = NUM_REQ'(1) << idx;
        grant_idx_o = TAG_W'(idx);
      end
    end
  end

endmodule

// File: rtl/quad_solver_arbiter.sv
// Round-robin sharing of one pipelined quadratic solver among NUM_REQ requesters.
// Optional: define QUAD_ARB_STATS_EN for stat_issued / stat_stall counters.
module quad_solver_arbiter
  import quad_arb_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int DATA_WIDTH     = DATA_WIDTH_DEF,
  parameter int SOLVER_LATENCY = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_a,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_b,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_c,
  output logic [NUM_REQ-1:0]            resp_valid,
  input  logic [NUM_REQ-1:0]            resp_ready,
  output logic [NUM_REQ*DATA_WIDTH-1:0] resp_x0,
  output logic [NUM_REQ*DATA_WIDTH-1:0] resp_x1,
  output logic [DATA_WIDTH-1:0]         sol_a,
  output logic [DATA_WIDTH-1:0]         sol_b,
  output logic [DATA_WIDTH-1:0]         sol_c,
  output logic                          sol_start,
  input  logic [DATA_WIDTH-1:0]         sol_x0,
  input  logic [DATA_WIDTH-1:0]         sol_x1,
  input  logic                          sol_valid,
  output logic                          sync_err
`ifdef QUAD_ARB_STATS_EN
  ,
  output logic [31:0]                   stat_issued,
  output logic [31:0]                   stat_stall
`endif
);

  localparam int TAG_W = $clog2(NUM_REQ);
  localparam int NW    = NUM_REQ * DATA_WIDTH;

  logic [NUM_REQ-1:0]    pending_q, pending_d, resp_valid_q, resp_valid_d;
  logic [NUM_REQ-1:0]    eligible, grant, resp_hs;
  logic [TAG_W-1:0]      rr_ptr_q, rr_ptr_d, gnt_idx;
  logic                  any_grant;
  logic [DATA_WIDTH-1:0] sol_a_q, sol_a_d, sol_b_q, sol_b_d, sol_c_q, sol_c_d;
  logic [NW-1:0]         x0_q, x0_d, x1_q, x1_d;
  logic                  sync_err_q, sync_err_d;
  tag_t                  iss_q, iss_d, head;
  tag_t                  pipe_q [SOLVER_LATENCY];

  assign eligible = req_valid & ~pending_q;
  assign resp_hs  = resp_valid_q & resp_ready;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .eligible_i  (eligible),
    .rr_ptr_i    (rr_ptr_q),
    .grant_o     (grant),
    .grant_idx_o (gnt_idx),
    .any_grant_o (any_grant)
  );

  // The issue register is the first tag stage, so the tag pipe behind it
  // reaches its head in the same cycle the solver raises sol_valid.
  assign head = pipe_q[SOLVER_LATENCY-1];

  always_comb begin
    pending_d = (pending_q | grant) & ~resp_hs;
    rr_ptr_d  = rr_ptr_q;
    if (any_grant) rr_ptr_d = (gnt_idx == TAG_W'(NUM_REQ - 1)) ? '0 : gnt_idx + TAG_W'(1);
    iss_d.valid = any_grant;
    iss_d.idx   = IDX_W'(gnt_idx);
    sol_a_d = sol_a_q;
    sol_b_d = sol_b_q;
    sol_c_d = sol_c_q;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        sol_a_d = req_a[i*DATA_WIDTH +: DATA_WIDTH];
        sol_b_d = req_b[i*DATA_WIDTH +: DATA_WIDTH];
        sol_c_d = req_c[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
    resp_valid_d = resp_valid_q & ~resp_hs;
    x0_d = x0_q;
    x1_d = x1_q;
    if (head.valid && sol_valid) begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        if (head.idx == IDX_W'(i)) begin
          resp_valid_d[i]                  = 1'b1;
          x0_d[i*DATA_WIDTH +: DATA_WIDTH] = sol_x0;
          x1_d[i*DATA_WIDTH +: DATA_WIDTH] = sol_x1;
        end
      end
    end
    sync_err_d = sync_err_q | (head.valid ^ sol_valid);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending_q    <= '0;
      resp_valid_q <= '0;
      rr_ptr_q     <= '0;
      iss_q        <= '0;
      sol_a_q      <= '0;
      sol_b_q      <= '0;
      sol_c_q      <= '0;
      x0_q         <= '0;
      x1_q         <= '0;
      sync_err_q   <= 1'b0;
      for (int unsigned j = 0; j < SOLVER_LATENCY; j++) pipe_q[j] <= '0;
    end else begin
      pending_q    <= pending_d;
      resp_valid_q <= resp_valid_d;
      rr_ptr_q     <= rr_ptr_d;
      iss_q        <= iss_d;
      sol_a_q      <= sol_a_d;
      sol_b_q      <= sol_b_d;
      sol_c_q      <= sol_c_d;
      x0_q         <= x0_d;
      x1_q         <= x1_d;
      sync_err_q   <= sync_err_d;
      pipe_q[0]    <= iss_q;
      for (int unsigned j = 1; j < SOLVER_LATENCY; j++) pipe_q[j] <= pipe_q[j-1];
    end
  end

  assign req_ready  = grant;
  assign resp_valid = resp_valid_q;
  assign resp_x0    = x0_q;
  assign resp_x1    = x1_q;
  assign sol_a      = sol_a_q;
  assign sol_b      = sol_b_q;
  assign sol_c      = sol_c_q;
  assign sol_start  = iss_q.valid;
  assign sync_err   = sync_err_q;

`ifdef QUAD_ARB_STATS_EN
  logic [31:0] stat_issued_q, stat_issued_d, stat_stall_q, stat_stall_d;

  always_comb begin
    stat_issued_d = stat_issued_q + (iss_q.valid ? 32'd1 : 32'd0);
    stat_stall_d  = stat_stall_q + ((|(req_valid & pending_q)) ? 32'd1 : 32'd0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_issued_q <= '0;
      stat_stall_q  <= '0;
    end else begin
      stat_issued_q <= stat_issued_d;
      stat_stall_q  <= stat_stall_d;
    end
  end

  assign stat_issued = stat_issued_q;
  assign stat_stall  = stat_stall_q;
`endif

endmodule
